// File: rtl/tdm_demux_1x8.sv
// Receive-side 8-channel TDM demultiplexer.
// Hunts for frame_sync, confirms alignment over LOCK_FRAMES frames, then
// flywheels through up to LOSS_FRAMES-1 consecutive sync errors while
// de-serialising each 8-beat frame into a parallel word.
module tdm_demux_1x8 #(
  parameter int unsigned LOCK_FRAMES = 2,
  parameter int unsigned LOSS_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic       din_valid,
  input  logic       frame_sync,
  output logic [7:0] dout,
  output logic       dout_valid,
  output logic [2:0] slot,
  output logic       locked,
  output logic       sync_err
);

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_CHECK,
    ST_LOCKED
  } state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);
  localparam logic [3:0] LOSS_N = 4'(LOSS_FRAMES);

  // State after a beat that opens a new alignment attempt.
  localparam state_t START_STATE = (LOCK_FRAMES == 1) ? ST_LOCKED : ST_CHECK;

  state_t     state_q, state_d;
  logic [2:0] slot_q, slot_d;
  logic [3:0] good_q, good_d;
  logic [3:0] bad_q, bad_d;
  logic [6:0] shadow_q, shadow_d;
  logic [7:0] dout_q, dout_d;
  logic       dout_valid_q, dout_valid_d;
  logic       sync_err_q, sync_err_d;

  // Per-beat actions decided by the state, applied in one place below.
  logic do_start;   // beat becomes slot 0 of a fresh alignment (good=1)
  logic do_hunt;    // drop back to HUNT with counters cleared
  logic do_store;   // store din at current slot and advance the slot counter
  logic do_emit;    // slot-7 beat completes a frame to be presented on dout
  logic at_zero;
  logic sync_error;
  logic [3:0] good_inc;
  logic [3:0] bad_inc;

  assign at_zero    = (slot_q == 3'd0);
  // Error while locked: missing sync at slot 0, or sync at any other slot.
  assign sync_error = at_zero ^ frame_sync;
  assign good_inc   = good_q + 4'd1;
  assign bad_inc    = bad_q + 4'd1;

  // Action decode: which of start/hunt/store/emit this beat triggers.
  always_comb begin
    do_start   = 1'b0;
    do_hunt    = 1'b0;
    do_store   = 1'b0;
    do_emit    = 1'b0;
    sync_err_d = 1'b0;
    if (din_valid) begin
      unique case (state_q)
        ST_HUNT: begin
          do_start = frame_sync;
        end
        ST_CHECK: begin
          if (frame_sync && !at_zero) begin
            do_start = 1'b1;
          end else if (at_zero && !frame_sync) begin
            do_hunt = 1'b1;
          end else begin
            do_store = 1'b1;
          end
        end
        ST_LOCKED: begin
          sync_err_d = sync_error;
          if (sync_error && (bad_inc >= LOSS_N)) begin
            // Lock lost: the offending beat is re-judged as if in HUNT.
            do_start = frame_sync;
            do_hunt  = !frame_sync;
          end else begin
            do_store = 1'b1;
            do_emit  = (slot_q == 3'd7);
          end
        end
        default: begin
          do_hunt = 1'b1;
        end
      endcase
    end
  end

  // Next-state, counters, shadow register and output word.
  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    good_d       = good_q;
    bad_d        = bad_q;
    shadow_d     = shadow_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;

    if (do_start) begin
      shadow_d[0] = din;
      slot_d      = 3'd1;
      good_d      = 4'd1;
      bad_d       = '0;
      state_d     = START_STATE;
    end else if (do_hunt) begin
      slot_d  = '0;
      good_d  = '0;
      bad_d   = '0;
      state_d = ST_HUNT;
    end else if (do_store) begin
      for (int unsigned i = 0; i < 7; i++) begin
        if (slot_q == 3'(i)) begin
          shadow_d[i] = din;
        end
      end
      slot_d = slot_q + 3'd1;

      if (state_q == ST_CHECK && at_zero) begin
        // Only reached with frame_sync present at slot 0.
        good_d = good_inc;
        if (good_inc >= LOCK_N) begin
          state_d = ST_LOCKED;
          bad_d   = '0;
        end
      end

      if (state_q == ST_LOCKED) begin
        if (sync_error) begin
          bad_d = bad_inc;
        end else if (at_zero) begin
          bad_d = '0;
        end
      end
    end

    if (do_emit) begin
      dout_d       = {din, shadow_q};
      dout_valid_d = 1'b1;
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_HUNT;
      slot_q       <= '0;
      good_q       <= '0;
      bad_q        <= '0;
      shadow_q     <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      good_q       <= good_d;
      bad_q        <= bad_d;
      shadow_q     <= shadow_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign slot       = slot_q;
  assign locked     = (state_q == ST_LOCKED);
  assign sync_err   = sync_err_q;

endmodule
